// File: rtl/trap_ctrl_if.sv
// Bundle of execute-stage, CSR-file and fetch-redirect signals around trap_ctrl.
// Suffixes are relative to trap_ctrl: the slave modport is the sequencer itself.
interface trap_ctrl_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 12
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic              is_ecall_i;
    logic              is_mret_i;
    logic [1:0]        csr_op_i;
    logic [ADDR_W-1:0] csr_addr_i;
    logic [XLEN-1:0]   src1_i;
    logic [XLEN-1:0]   pc_i;

    logic [ADDR_W-1:0] csr_addr_o;
    logic [XLEN-1:0]   csr_rdata_i;
    logic [XLEN-1:0]   mtvec_i;
    logic [XLEN-1:0]   mepc_i;
    logic              csr_wen_o;
    logic [XLEN-1:0]   csr_wdata_o;
    logic              csr_ecall_o;
    logic              csr_mret_o;
    logic [XLEN-1:0]   csr_mepc_o;
    logic [XLEN-1:0]   csr_mcause_o;

    logic              rd_wen_o;
    logic [XLEN-1:0]   rd_wdata_o;

    logic              redirect_valid_o;
    logic [XLEN-1:0]   redirect_pc_o;
    logic              redirect_ready_i;
    logic              busy_o;

    modport slave (
        input  in_valid_i, is_ecall_i, is_mret_i, csr_op_i, csr_addr_i, src1_i, pc_i,
        input  csr_rdata_i, mtvec_i, mepc_i, redirect_ready_i,
        output in_ready_o, csr_addr_o, csr_wen_o, csr_wdata_o, csr_ecall_o, csr_mret_o,
        output csr_mepc_o, csr_mcause_o, rd_wen_o, rd_wdata_o,
        output redirect_valid_o, redirect_pc_o, busy_o
    );

    modport master (
        output in_valid_i, is_ecall_i, is_mret_i, csr_op_i, csr_addr_i, src1_i, pc_i,
        output csr_rdata_i, mtvec_i, mepc_i, redirect_ready_i,
        input  in_ready_o, csr_addr_o, csr_wen_o, csr_wdata_o, csr_ecall_o, csr_mret_o,
        input  csr_mepc_o, csr_mcause_o, rd_wen_o, rd_wdata_o,
        input  redirect_valid_o, redirect_pc_o, busy_o
    );
endinterface

// File: rtl/trap_ctrl.sv
// System-instruction sequencer between execute and the M-mode CSR file:
// CSR read-modify-write, ecall trap entry and mret return with PC redirect.
module trap_ctrl #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned ECALL_CAUSE = 11
) (
    input  logic         clk_i,
    input  logic         rst_i,
    trap_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {StIdle, StExec, StRedirect} state_e;
    typedef enum logic [1:0] {KindNop, KindCsr, KindEcall, KindMret} kind_e;

    localparam logic [1:0]      OpRw  = 2'b01;
    localparam logic [1:0]      OpRs  = 2'b10;
    localparam logic [1:0]      OpRc  = 2'b11;
    localparam logic [XLEN-1:0] Cause = XLEN'(ECALL_CAUSE);
    localparam logic [XLEN-1:0] TvecMask = ~XLEN'(3);

    state_e            state_q;
    kind_e             kind_q;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   src1_q;
    logic [XLEN-1:0]   pc_q;

    logic              in_ready_q;
    logic              busy_q;
    logic              csr_wen_q;
    logic              csr_ecall_q;
    logic              csr_mret_q;
    logic              rd_wen_q;
    logic              redirect_valid_q;
    logic [XLEN-1:0]   redirect_pc_q;

    kind_e             in_kind;
    logic              in_wen;
    logic              exec_csr;
    logic              exec_ecall;
    logic [XLEN-1:0]   wdata;

    // Priority decode of the incoming instruction: ecall > mret > CSR op > nop.
    always_comb begin
        in_kind = KindNop;
        if (bus.is_ecall_i) begin
            in_kind = KindEcall;
        end else if (bus.is_mret_i) begin
            in_kind = KindMret;
        end else if (bus.csr_op_i != 2'b00) begin
            in_kind = KindCsr;
        end
        in_wen = (bus.csr_op_i == OpRw) || (bus.src1_i != '0);
    end

    // Strobes are precomputed at acceptance so they are registered during EXEC.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q          <= StIdle;
            kind_q           <= KindNop;
            op_q             <= 2'b00;
            addr_q           <= '0;
            src1_q           <= '0;
            pc_q             <= '0;
            in_ready_q       <= 1'b1;
            busy_q           <= 1'b0;
            csr_wen_q        <= 1'b0;
            csr_ecall_q      <= 1'b0;
            csr_mret_q       <= 1'b0;
            rd_wen_q         <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            csr_wen_q   <= 1'b0;
            csr_ecall_q <= 1'b0;
            csr_mret_q  <= 1'b0;
            rd_wen_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid_i) begin
                        kind_q      <= in_kind;
                        op_q        <= bus.csr_op_i;
                        addr_q      <= bus.csr_addr_i;
                        src1_q      <= bus.src1_i;
                        pc_q        <= bus.pc_i;
                        state_q     <= StExec;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        csr_wen_q   <= (in_kind == KindCsr) && in_wen;
                        rd_wen_q    <= (in_kind == KindCsr);
                        csr_ecall_q <= (in_kind == KindEcall);
                        csr_mret_q  <= (in_kind == KindMret);
                    end
                end
                StExec: begin
                    // mtvec/mepc sampled here, before the CSR file applies this cycle's update.
                    unique case (kind_q)
                        KindEcall: begin
                            redirect_pc_q    <= bus.mtvec_i & TvecMask;
                            redirect_valid_q <= 1'b1;
                            state_q          <= StRedirect;
                        end
                        KindMret: begin
                            redirect_pc_q    <= bus.mepc_i;
                            redirect_valid_q <= 1'b1;
                            state_q          <= StRedirect;
                        end
                        default: begin
                            state_q    <= StIdle;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end
                    endcase
                end
                StRedirect: begin
                    if (bus.redirect_ready_i) begin
                        redirect_valid_q <= 1'b0;
                        state_q          <= StIdle;
                        in_ready_q       <= 1'b1;
                        busy_q           <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign exec_csr   = (state_q == StExec) && (kind_q == KindCsr);
    assign exec_ecall = (state_q == StExec) && (kind_q == KindEcall);

    // Write data depends on the CSR file's same-cycle read data, so it stays combinational.
    always_comb begin
        wdata = '0;
        if (exec_csr) begin
            unique case (op_q)
                OpRw:    wdata = src1_q;
                OpRs:    wdata = bus.csr_rdata_i | src1_q;
                OpRc:    wdata = bus.csr_rdata_i & ~src1_q;
                default: wdata = '0;
            endcase
        end
    end

    assign bus.in_ready_o       = in_ready_q;
    assign bus.busy_o           = busy_q;
    assign bus.csr_addr_o       = exec_csr ? addr_q : '0;
    assign bus.csr_wen_o        = csr_wen_q;
    assign bus.csr_wdata_o      = wdata;
    assign bus.csr_ecall_o      = csr_ecall_q;
    assign bus.csr_mret_o       = csr_mret_q;
    assign bus.csr_mepc_o       = exec_ecall ? pc_q : '0;
    assign bus.csr_mcause_o     = exec_ecall ? Cause : '0;
    assign bus.rd_wen_o         = rd_wen_q;
    assign bus.rd_wdata_o       = exec_csr ? bus.csr_rdata_i : '0;
    assign bus.redirect_valid_o = redirect_valid_q;
    assign bus.redirect_pc_o    = redirect_pc_q;
endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-timeline model.
module tb_trap_ctrl;
    logic clk;
    logic rst_i;

    trap_ctrl_if #(.XLEN(32), .ADDR_W(12)) bus ();

    trap_ctrl #(.XLEN(32), .ADDR_W(12), .ECALL_CAUSE(11)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: the one instruction most recently accepted and where it is on its timeline.
    // kind: 0 nop, 1 csr, 2 ecall, 3 mret.
    bit          m_have     = 1'b0;
    int          m_acc      = 0;
    int          m_kind     = 0;
    logic [1:0]  m_op       = '0;
    logic [11:0] m_addr     = '0;
    logic [31:0] m_src1     = '0;
    logic [31:0] m_pc       = '0;
    logic [31:0] m_tgt      = '0;
    bit          m_rel_done = 1'b0;
    int          m_rel      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    // 0 idle, 1 exec, 2 redirect, as a function of cycles since acceptance.
    function automatic int phase_at(input int c);
        if (!m_have || c <= m_acc) return 0;
        if (c == m_acc + 1) return 1;
        if (m_kind >= 2) begin
            if (m_rel_done && c > m_rel) return 0;
            return 2;
        end
        return 0;
    endfunction

    function automatic int kind_of(input bit e, input bit m, input logic [1:0] op);
        if (e) return 2;
        if (m) return 3;
        if (op != 2'b00) return 1;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            m_have     <= 1'b0;
            m_rel_done <= 1'b0;
        end else begin
            case (phase_at(cyc))
                0: if (bus.in_valid_i) begin
                    m_have     <= 1'b1;
                    m_acc      <= cyc;
                    m_rel_done <= 1'b0;
                    m_kind     <= kind_of(bus.is_ecall_i, bus.is_mret_i, bus.csr_op_i);
                    m_op       <= bus.csr_op_i;
                    m_addr     <= bus.csr_addr_i;
                    m_src1     <= bus.src1_i;
                    m_pc       <= bus.pc_i;
                end
                1: begin
                    if (m_kind == 2) m_tgt <= {bus.mtvec_i[31:2], 2'b00};
                    if (m_kind == 3) m_tgt <= bus.mepc_i;
                end
                2: if (bus.redirect_ready_i) begin
                    m_rel_done <= 1'b1;
                    m_rel      <= cyc;
                end
                default: ;
            endcase
            cyc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        int          ph;
        logic [31:0] old;
        logic        e_wen, e_ecall, e_mret, e_rdwen;
        logic [31:0] e_addr, e_wdata, e_mepc, e_mcause, e_rdw;
        ph = phase_at(cyc);
        old = bus.csr_rdata_i;
        e_wen = 0; e_ecall = 0; e_mret = 0; e_rdwen = 0;
        e_addr = 0; e_wdata = 0; e_mepc = 0; e_mcause = 0; e_rdw = 0;
        if (ph == 1) begin
            case (m_kind)
                1: begin
                    e_addr  = {20'd0, m_addr};
                    e_rdwen = 1;
                    e_rdw   = old;
                    e_wen   = (m_op == 2'b01) || (m_src1 != 0);
                    if (m_op == 2'b01)      e_wdata = m_src1;
                    else if (m_op == 2'b10) e_wdata = old | m_src1;
                    else                    e_wdata = old & ~m_src1;
                end
                2: begin
                    e_ecall  = 1;
                    e_mepc   = m_pc;
                    e_mcause = 11;
                end
                3: e_mret = 1;
                default: ;
            endcase
        end
        chk("in_ready", 32'(bus.in_ready_o), 32'(ph == 0));
        chk("busy", 32'(bus.busy_o), 32'(ph != 0));
        chk("redirect_valid", 32'(bus.redirect_valid_o), 32'(ph == 2));
        chk("csr_wen", 32'(bus.csr_wen_o), 32'(e_wen));
        chk("csr_ecall", 32'(bus.csr_ecall_o), 32'(e_ecall));
        chk("csr_mret", 32'(bus.csr_mret_o), 32'(e_mret));
        chk("rd_wen", 32'(bus.rd_wen_o), 32'(e_rdwen));
        chk("csr_addr", 32'(bus.csr_addr_o), e_addr);
        chk("csr_wdata", bus.csr_wdata_o, e_wdata);
        chk("csr_mepc", bus.csr_mepc_o, e_mepc);
        chk("csr_mcause", bus.csr_mcause_o, e_mcause);
        chk("rd_wdata", bus.rd_wdata_o, e_rdw);
        if (ph == 2) chk("redirect_pc", bus.redirect_pc_o, m_tgt);
    end

    // Called just after an edge in an idle cycle; returns just after the accepting edge.
    task automatic issue(input bit e, input bit m, input logic [1:0] op,
                         input logic [11:0] a, input logic [31:0] s, input logic [31:0] p);
        bus.in_valid_i = 1'b1;
        bus.is_ecall_i = e;
        bus.is_mret_i  = m;
        bus.csr_op_i   = op;
        bus.csr_addr_i = a;
        bus.src1_i     = s;
        bus.pc_i       = p;
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        bus.is_ecall_i = 1'b0;
        bus.is_mret_i  = 1'b0;
        bus.csr_op_i   = 2'b00;
    endtask

    initial begin
        int n;
        bus.in_valid_i = 0; bus.is_ecall_i = 0; bus.is_mret_i = 0; bus.csr_op_i = 0;
        bus.csr_addr_i = 0; bus.src1_i = 0; bus.pc_i = 0; bus.csr_rdata_i = 0;
        bus.mtvec_i = 0; bus.mepc_i = 0; bus.redirect_ready_i = 0;
        rst_i = 1'b1;
        #1 rst_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", 32'(bus.in_ready_o), 32'd1);
        chk("reset redirect_valid", 32'(bus.redirect_valid_o), 32'd0);
        @(posedge clk);
        #1 rst_i = 1'b1;

        // Reset while a redirect is pending.
        bus.mtvec_i = 32'h8000_0100;
        issue(1, 0, 2'b00, 12'h0, 32'h0, 32'h8000_0010);
        repeat (2) begin @(posedge clk); #1; end
        rst_i = 1'b0;
        #2 rst_i = 1'b1;
        @(negedge clk);
        chk("rst mid redirect valid", 32'(bus.redirect_valid_o), 32'd0);
        chk("rst mid redirect ready", 32'(bus.in_ready_o), 32'd1);
        chk("rst mid redirect ecall", 32'(bus.csr_ecall_o), 32'd0);
        @(posedge clk); #1;

        // CSR RW.
        bus.csr_rdata_i = 32'h0000_1234;
        issue(0, 0, 2'b01, 12'h305, 32'h8000_0100, 32'h0);
        @(negedge clk);
        chk("rw wen", 32'(bus.csr_wen_o), 32'd1);
        chk("rw wdata", bus.csr_wdata_o, 32'h8000_0100);
        chk("rw rd_wdata", bus.rd_wdata_o, 32'h0000_1234);
        chk("rw addr", 32'(bus.csr_addr_o), 32'h305);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rw idle T+2", 32'(bus.in_ready_o), 32'd1);
        @(posedge clk); #1;

        // RS / RC / RS with zero.
        bus.csr_rdata_i = 32'h0000_1800;
        issue(0, 0, 2'b10, 12'h300, 32'h8, 32'h0);
        @(negedge clk);
        chk("rs wdata", bus.csr_wdata_o, 32'h0000_1808);
        chk("rs wen", 32'(bus.csr_wen_o), 32'd1);
        @(posedge clk); #1;
        issue(0, 0, 2'b11, 12'h300, 32'h800, 32'h0);
        @(negedge clk);
        chk("rc wdata", bus.csr_wdata_o, 32'h0000_1000);
        @(posedge clk); #1;
        issue(0, 0, 2'b10, 12'h300, 32'h0, 32'h0);
        @(negedge clk);
        chk("rs0 wen", 32'(bus.csr_wen_o), 32'd0);
        chk("rs0 rd_wen", 32'(bus.rd_wen_o), 32'd1);
        @(posedge clk); #1;

        // ecall with redirect held off; mtvec changes afterwards must not leak.
        bus.mtvec_i = 32'h8000_0203;
        issue(1, 0, 2'b00, 12'h0, 32'h0, 32'h8000_0040);
        @(negedge clk);
        chk("ecall strobe", 32'(bus.csr_ecall_o), 32'd1);
        chk("ecall mepc", bus.csr_mepc_o, 32'h8000_0040);
        chk("ecall mcause", bus.csr_mcause_o, 32'd11);
        chk("ecall wen", 32'(bus.csr_wen_o), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            bus.mtvec_i = 32'hFFFF_FFFF;
            @(negedge clk);
            chk("ecall held valid", 32'(bus.redirect_valid_o), 32'd1);
            chk("ecall held pc", bus.redirect_pc_o, 32'h8000_0200);
        end
        @(posedge clk); #1;
        bus.redirect_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.redirect_ready_i = 1'b0;
        @(negedge clk);
        chk("ecall released", 32'(bus.redirect_valid_o), 32'd0);
        chk("ecall idle", 32'(bus.in_ready_o), 32'd1);
        @(posedge clk); #1;

        // mret.
        bus.mepc_i = 32'h8000_0044;
        issue(0, 1, 2'b00, 12'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("mret strobe", 32'(bus.csr_mret_o), 32'd1);
        chk("mret no ecall", 32'(bus.csr_ecall_o), 32'd0);
        @(posedge clk); #1;
        bus.redirect_ready_i = 1'b1;
        @(negedge clk);
        chk("mret strobe gone", 32'(bus.csr_mret_o), 32'd0);
        chk("mret pc", bus.redirect_pc_o, 32'h8000_0044);
        @(posedge clk); #1;
        bus.redirect_ready_i = 1'b0;

        // ecall and mret both set: ecall wins, CSR op ignored.
        bus.mtvec_i = 32'h0000_0100;
        bus.mepc_i  = 32'h0000_0200;
        issue(1, 1, 2'b01, 12'h305, 32'h5, 32'h44);
        @(negedge clk);
        chk("both ecall", 32'(bus.csr_ecall_o), 32'd1);
        chk("both mret", 32'(bus.csr_mret_o), 32'd0);
        chk("both wen", 32'(bus.csr_wen_o), 32'd0);
        @(posedge clk); #1;
        bus.redirect_ready_i = 1'b1;
        @(negedge clk);
        chk("both pc", bus.redirect_pc_o, 32'h0000_0100);
        @(posedge clk); #1;
        bus.redirect_ready_i = 1'b0;

        // Back-to-back valid: only every other cycle is accepted.
        n = 0;
        bus.in_valid_i = 1'b1;
        bus.csr_op_i   = 2'b01;
        bus.src1_i     = 32'h1;
        repeat (4) begin
            @(negedge clk);
            n += int'(bus.csr_wen_o);
            @(posedge clk); #1;
        end
        bus.in_valid_i = 1'b0;
        bus.csr_op_i   = 2'b00;
        chk("b2b strobes", 32'(n), 32'd2);

        // Random traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            @(posedge clk); #1;
            bus.in_valid_i       = ($urandom_range(0, 1) == 1);
            bus.is_ecall_i       = ($urandom_range(0, 7) == 0);
            bus.is_mret_i        = ($urandom_range(0, 7) == 0);
            bus.csr_op_i         = 2'($urandom_range(0, 3));
            bus.csr_addr_i       = 12'($urandom);
            bus.src1_i           = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            bus.pc_i             = $urandom;
            bus.csr_rdata_i      = $urandom;
            bus.mtvec_i          = $urandom;
            bus.mepc_i           = $urandom;
            bus.redirect_ready_i = ($urandom_range(0, 2) == 0);
        end
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
